// File: rtl/dma_read_streamer_if.sv
// dma_read_streamer_if: engine-facing DMA read-port bundle.
// slave = streamer side, master = engine side.
interface dma_read_streamer_if #(
  parameter int DATA_W = 16,
  parameter int NCH    = 2
);
  logic [NCH-1:0]        reads_en;
  logic [NCH-1:0]        ob_we;
  logic [NCH*DATA_W-1:0] ob_data;
  logic [NCH-1:0]        ch_done;
  logic [NCH-1:0]        underrun;

  modport slave (
    input  reads_en,
    output ob_we,
    output ob_data,
    output ch_done,
    output underrun
  );

  modport master (
    output reads_en,
    input  ob_we,
    input  ob_data,
    input  ch_done,
    input  underrun
  );
endinterface

// File: rtl/dma_read_streamer.sv
// dma_read_streamer: NCH preloadable banks streamed with per-word repeat.
// Optional write-port capture buffer: define DMA_WRITE_CAPTURE_EN.
module dma_read_streamer #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 2,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int CAP_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                ld_we,
  input  logic [7:0]          ld_ch,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [NCH*ADDR_W-1:0] cfg_len,
  input  logic [NCH*4-1:0]    cfg_rep,
  input  logic [NCH-1:0]      cfg_wrap,
  dma_read_streamer_if.slave  bus,
  input  logic                writes_en,
  input  logic [DATA_W-1:0]   ib_data,
  output logic [7:0]          cap_count,
  input  logic [7:0]          cap_rd_addr,
  output logic [DATA_W-1:0]   cap_rd_data
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_END
  } st_t;

  st_t               state_q [NCH];
  st_t               state_d [NCH];
  logic [ADDR_W-1:0] ptr     [NCH];
  logic [3:0]        rcnt    [NCH];
  logic [ADDR_W-1:0] last_q  [NCH];
  logic [3:0]        rlast_q [NCH];
  logic [NCH-1:0]    wrap_q;
  logic [NCH-1:0]    served;
  logic [NCH-1:0]    fin;
  logic [NCH-1:0]    start;

  logic [DATA_W-1:0] bank [NCH][DEPTH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      served[c]  = 1'b0;
      fin[c]     = 1'b0;
      start[c]   = 1'b0;
      if (!run) begin
        state_d[c] = S_IDLE;
      end else begin
        unique case (state_q[c])
          S_IDLE: begin
            start[c]   = 1'b1;
            state_d[c] = S_STREAM;
          end
          S_STREAM: begin
            served[c] = bus.reads_en[c];
            fin[c]    = served[c]
                     && (rcnt[c] == rlast_q[c])
                     && (ptr[c] == last_q[c]);
            if (fin[c] && !wrap_q[c])
              state_d[c] = S_END;
          end
          S_END: served[c] = bus.reads_en[c];
          default: state_d[c] = S_IDLE;
        endcase
      end
    end
  end

  // len 0 wraps to DEPTH-1 as last index; rep 0 behaves as 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= S_IDLE;
        ptr[c]     <= '0;
        rcnt[c]    <= '0;
        last_q[c]  <= '0;
        rlast_q[c] <= '0;
      end
      wrap_q       <= '0;
      bus.ob_we    <= '0;
      bus.ob_data  <= '0;
      bus.ch_done  <= '0;
      bus.underrun <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]     <= state_d[c];
        bus.ob_we[c]   <= served[c];
        bus.ch_done[c] <= fin[c];
        if (start[c]) begin
          last_q[c] <= cfg_len[c*ADDR_W +: ADDR_W]
                     - ADDR_W'(1);
          rlast_q[c] <= (cfg_rep[c*4 +: 4] == 4'd0)
                      ? 4'd0
                      : cfg_rep[c*4 +: 4] - 4'd1;
          wrap_q[c] <= cfg_wrap[c];
        end
        if (!run) begin
          ptr[c]          <= '0;
          rcnt[c]         <= '0;
          bus.underrun[c] <= 1'b0;
        end else if (served[c]) begin
          if (state_q[c] == S_END) begin
            bus.ob_data[c*DATA_W +: DATA_W] <= '0;
            bus.underrun[c] <= 1'b1;
          end else begin
            bus.ob_data[c*DATA_W +: DATA_W] <= bank[c][ptr[c]];
            if (rcnt[c] == rlast_q[c]) begin
              rcnt[c] <= '0;
              ptr[c]  <= (ptr[c] == last_q[c])
                       ? '0
                       : ptr[c] + ADDR_W'(1);
            end else begin
              rcnt[c] <= rcnt[c] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && (32'(ld_ch) < NCH))
      bank[ld_ch[CH_W-1:0]][ld_addr] <= ld_data;
  end

`ifdef DMA_WRITE_CAPTURE_EN
  localparam int CAP_AW = $clog2(CAP_DEPTH);

  logic [DATA_W-1:0] cap_buf [CAP_DEPTH];
  logic              run_q;
  logic              cap_wr;

  assign cap_wr = run && run_q && writes_en
               && (32'(cap_count) < CAP_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q     <= 1'b0;
      cap_count <= '0;
    end else begin
      run_q <= run;
      if (run && !run_q)
        cap_count <= '0;
      else if (cap_wr)
        cap_count <= cap_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && cap_wr)
      cap_buf[cap_count[CAP_AW-1:0]] <= ib_data;
  end

  assign cap_rd_data = (32'(cap_rd_addr) < CAP_DEPTH)
                     ? cap_buf[cap_rd_addr[CAP_AW-1:0]]
                     : '0;
`else
  logic unused_cap;
  assign unused_cap  = ^{writes_en, ib_data, cap_rd_addr,
                         CAP_DEPTH[0]};
  assign cap_count   = '0;
  assign cap_rd_data = '0;
`endif
endmodule

// File: tb/tb_dma_read_streamer.sv
// tb_dma_read_streamer: directed tables, corner sequences and
// randomized traffic against a request-count reference model.
module tb_dma_read_streamer;
  logic        clk;
  logic        rst;
  logic        run;
  logic        ld_we;
  logic [7:0]  ld_ch;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_rep;
  logic [1:0]  cfg_wrap;
  logic        writes_en;
  logic [15:0] ib_data;
  logic [7:0]  cap_count;
  logic [7:0]  cap_rd_addr;
  logic [15:0] cap_rd_data;

  int tests = 0;
  int fails = 0;

  dma_read_streamer_if #(.DATA_W(16), .NCH(2)) bus ();

  dma_read_streamer #(
    .DATA_W(16), .NCH(2), .DEPTH(256),
    .ADDR_W(8), .CAP_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .ld_we(ld_we), .ld_ch(ld_ch),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_len(cfg_len), .cfg_rep(cfg_rep),
    .cfg_wrap(cfg_wrap), .bus(bus),
    .writes_en(writes_en), .ib_data(ib_data),
    .cap_count(cap_count),
    .cap_rd_addr(cap_rd_addr),
    .cap_rd_data(cap_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [15:0] data;
    logic        done;
    logic        ur;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_cfg(input int c, input logic [7:0] len,
                         input logic [3:0] rep, input logic wr);
    cfg_len[c*8 +: 8] = len;
    cfg_rep[c*4 +: 4] = rep;
    cfg_wrap[c]       = wr;
  endtask

  task automatic load(input logic [7:0] ch, input logic [7:0] a,
                      input logic [15:0] d);
    ld_we = 1'b1; ld_ch = ch; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic req(input logic [1:0] re);
    bus.reads_en = re;
    tick();
  endtask

  function automatic logic [15:0] d0();
    return bus.ob_data[15:0];
  endfunction

  function automatic logic [15:0] d1();
    return bus.ob_data[31:16];
  endfunction

  vec_t t1 [7];
  logic [15:0] mbank [2][16];
  int   k [2];
  int   ml [2];
  int   mr [2];
  bit   mw [2];
  logic [1:0]  mur;
  logic [15:0] mdat [2];
  logic [1:0]  ewe;
  logic [1:0]  edone;
  bit   prev_run;
  int   tot;
  int   m;

  initial begin
    t1[0] = '{1'b1, 1'b1, 16'hce83, 1'b0, 1'b0};
    t1[1] = '{1'b1, 1'b1, 16'h4f98, 1'b0, 1'b0};
    t1[2] = '{1'b1, 1'b1, 16'h4e17, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    t1[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    t1[5] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1};
    t1[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst = 1'b0; run = 1'b0; ld_we = 1'b0; ld_ch = '0;
    ld_addr = '0; ld_data = '0; cfg_len = '0;
    cfg_rep = '0; cfg_wrap = '0; writes_en = 1'b0;
    ib_data = '0; cap_rd_addr = '0; bus.reads_en = '0;
    tick(); tick();
    chk("rst_we", 32'(bus.ob_we), 0);
    chk("rst_data", bus.ob_data, 0);
    chk("rst_done", 32'(bus.ch_done), 0);
    chk("rst_ur", 32'(bus.underrun), 0);
    chk("rst_cap", 32'(cap_count), 0);
    rst = 1'b1;

    // basic stream, then underrun after end
    load(0, 0, 16'hce83); load(0, 1, 16'h4f98);
    load(0, 2, 16'h4e17); load(0, 3, 16'h0000);
    set_cfg(0, 4, 1, 0); set_cfg(1, 1, 1, 0);
    run = 1'b1; tick();
    for (int i = 0; i < 7; i++) begin
      req({1'b0, t1[i].re});
      chk($sformatf("t1_we%0d", i), 32'(bus.ob_we[0]), 32'(t1[i].we));
      chk($sformatf("t1_d%0d", i), 32'(d0()), 32'(t1[i].data));
      chk($sformatf("t1_done%0d", i), 32'(bus.ch_done[0]), 32'(t1[i].done));
      chk($sformatf("t1_ur%0d", i), 32'(bus.underrun[0]), 32'(t1[i].ur));
    end

    // 8x repeat broadcast
    run = 1'b0; bus.reads_en = '0; tick();
    load(0, 0, 16'h4880); load(0, 1, 16'h4400);
    set_cfg(0, 2, 8, 0);
    run = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      req(2'b01);
      chk($sformatf("t2_d%0d", i), 32'(d0()),
          (i < 8) ? 32'h4880 : 32'h4400);
      chk($sformatf("t2_done%0d", i), 32'(bus.ch_done[0]),
          32'(i == 15));
    end
    req(2'b00);
    chk("t2_hold_we", 32'(bus.ob_we[0]), 0);
    chk("t2_hold_d", 32'(d0()), 32'h4400);

    // wrap off vs on
    run = 1'b0; tick();
    set_cfg(0, 2, 1, 0);
    run = 1'b1; tick();
    req(2'b01); chk("t3_d0", 32'(d0()), 32'h4880);
    req(2'b01); chk("t3_done", 32'(bus.ch_done[0]), 1);
    req(2'b01); chk("t3_d2", 32'(d0()), 0);
    chk("t3_ur", 32'(bus.underrun[0]), 1);
    chk("t3_we", 32'(bus.ob_we[0]), 1);
    run = 1'b0; req(2'b00);
    chk("t3_urclr", 32'(bus.underrun[0]), 0);
    set_cfg(0, 2, 1, 1);
    run = 1'b1; tick();
    req(2'b01); req(2'b01);
    chk("t3w_done", 32'(bus.ch_done[0]), 1);
    req(2'b01);
    chk("t3w_d2", 32'(d0()), 32'h4880);
    chk("t3w_ur", 32'(bus.underrun[0]), 0);

    // run drop mid-stream
    run = 1'b0; bus.reads_en = '0; tick();
    load(0, 0, 16'h1111); load(0, 1, 16'h2222);
    load(0, 2, 16'h3333); load(0, 3, 16'h4444);
    set_cfg(0, 4, 1, 0);
    run = 1'b1; tick();
    req(2'b01); chk("t4_d0", 32'(d0()), 32'h1111);
    req(2'b01); chk("t4_d1", 32'(d0()), 32'h2222);
    run = 1'b0;
    req(2'b01); chk("t4_drop", 32'(bus.ob_we[0]), 0);
    req(2'b01); chk("t4_idle", 32'(bus.ob_we[0]), 0);
    run = 1'b1; req(2'b00);
    req(2'b01); chk("t4_restart", 32'(d0()), 32'h1111);
    chk("t4_ur", 32'(bus.underrun[0]), 0);

    // two channels, ignored bank index, reset mid-stream
    run = 1'b0; bus.reads_en = '0; tick();
    load(1, 0, 16'ha001); load(1, 1, 16'ha002);
    load(1, 2, 16'ha003); load(5, 0, 16'hdead);
    set_cfg(0, 4, 1, 1); set_cfg(1, 3, 2, 1);
    run = 1'b1; tick();
    req(2'b11); chk("t5_a0", 32'(d0()), 32'h1111);
    chk("t5_b0", 32'(d1()), 32'ha001);
    req(2'b11); chk("t5_a1", 32'(d0()), 32'h2222);
    chk("t5_b1", 32'(d1()), 32'ha001);
    req(2'b11); chk("t5_a2", 32'(d0()), 32'h3333);
    chk("t5_b2", 32'(d1()), 32'ha002);
    req(2'b11); chk("t5_a3", 32'(d0()), 32'h4444);
    chk("t5_b3", 32'(d1()), 32'ha002);
    rst = 1'b0; req(2'b11);
    chk("t5_rst_we", 32'(bus.ob_we), 0);
    chk("t5_rst_d", bus.ob_data, 0);
    chk("t5_rst_done", 32'(bus.ch_done), 0);
    rst = 1'b1; req(2'b00);
    req(2'b11); chk("t5_keep_a", 32'(d0()), 32'h1111);
    chk("t5_keep_b", 32'(d1()), 32'ha001);
    ld_we = 1'b1; ld_ch = 0; ld_addr = 1; ld_data = 16'h5555;
    req(2'b11); ld_we = 1'b0;
    chk("t5_old", 32'(d0()), 32'h2222);
    run = 1'b0; req(2'b00);
    run = 1'b1; req(2'b00);
    req(2'b01); req(2'b01);
    chk("t5_new", 32'(d0()), 32'h5555);

    // len 0 means full depth
    run = 1'b0; bus.reads_en = '0; tick();
    set_cfg(0, 0, 1, 0);
    run = 1'b1; tick();
    for (int i = 0; i < 256; i++) begin
      req(2'b01);
      chk($sformatf("t7_done%0d", i), 32'(bus.ch_done[0]),
          32'(i == 255));
    end
    req(2'b01);
    chk("t7_ur", 32'(bus.underrun[0]), 1);
    chk("t7_d", 32'(d0()), 0);

    // write capture
    run = 1'b0; bus.reads_en = '0; tick();
    run = 1'b1; tick();
    writes_en = 1'b1;
    ib_data = 16'ha35c; tick();
    ib_data = 16'h3c00; tick();
    ib_data = 16'h0000; tick();
    writes_en = 1'b0; tick();
`ifdef DMA_WRITE_CAPTURE_EN
    chk("cap_cnt3", 32'(cap_count), 3);
    cap_rd_addr = 0; #1; chk("cap_rd0", 32'(cap_rd_data), 32'ha35c);
    cap_rd_addr = 1; #1; chk("cap_rd1", 32'(cap_rd_data), 32'h3c00);
    cap_rd_addr = 2; #1; chk("cap_rd2", 32'(cap_rd_data), 0);
    writes_en = 1'b1;
    for (int i = 0; i < 66; i++) begin
      ib_data = 16'h1000 + 16'(i);
      tick();
    end
    writes_en = 1'b0; tick();
    chk("cap_sat", 32'(cap_count), 64);
    cap_rd_addr = 63; #1;
    chk("cap_rd63", 32'(cap_rd_data), 32'h103c);
    cap_rd_addr = 0; #1;
    chk("cap_keep0", 32'(cap_rd_data), 32'ha35c);
`else
    chk("cap_off_cnt", 32'(cap_count), 0);
    cap_rd_addr = 0; #1;
    chk("cap_off_rd", 32'(cap_rd_data), 0);
`endif

    // randomized traffic vs request-count model
    run = 1'b0; rst = 1'b0; tick(); rst = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++) begin
        mbank[c][a] = 16'($urandom);
        load(8'(c), 8'(a), mbank[c][a]);
      end
    prev_run = 1'b0; mur = '0;
    for (int c = 0; c < 2; c++) begin
      k[c] = 0; mdat[c] = '0; ml[c] = 1; mr[c] = 1; mw[c] = 0;
    end
    for (int i = 0; i < 400; i++) begin
      if (i == 0) run = 1'b1;
      else if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0)
        for (int c = 0; c < 2; c++)
          set_cfg(c, 8'($urandom_range(1, 6)),
                  4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
      bus.reads_en = 2'($urandom_range(0, 3));
      ld_we   = ($urandom_range(0, 2) == 0);
      ld_ch   = 8'($urandom_range(0, 3));
      ld_addr = 8'($urandom_range(0, 15));
      ld_data = 16'($urandom);
      for (int c = 0; c < 2; c++) begin
        ewe[c] = 1'b0; edone[c] = 1'b0;
        if (!run) begin
          k[c] = 0; mur[c] = 1'b0;
        end else if (!prev_run) begin
          ml[c] = (cfg_len[c*8 +: 8] == 0) ? 256
                : int'(cfg_len[c*8 +: 8]);
          mr[c] = (cfg_rep[c*4 +: 4] == 0) ? 1
                : int'(cfg_rep[c*4 +: 4]);
          mw[c] = cfg_wrap[c];
          k[c] = 0;
        end else if (bus.reads_en[c]) begin
          tot = ml[c] * mr[c];
          ewe[c] = 1'b1;
          m = mw[c] ? (k[c] % tot) : k[c];
          if (m < tot) begin
            mdat[c] = mbank[c][m / mr[c]];
            edone[c] = (m == tot - 1);
          end else begin
            mdat[c] = '0;
            mur[c] = 1'b1;
          end
          k[c]++;
        end
      end
      prev_run = run;
      if (ld_we && ld_ch < 2)
        mbank[ld_ch[0]][ld_addr[3:0]] = ld_data;
      tick();
      chk($sformatf("rnd_we%0d", i), 32'(bus.ob_we), 32'(ewe));
      chk($sformatf("rnd_d%0d", i), bus.ob_data,
          {mdat[1], mdat[0]});
      chk($sformatf("rnd_done%0d", i), 32'(bus.ch_done),
          32'(edone));
      chk($sformatf("rnd_ur%0d", i), 32'(bus.underrun),
          32'(mur));
    end
    ld_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
